// File: rtl/seq_detect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl_pkg
//
// Shared definitions for the serial sequence-detector scheduler.
//   ctrl_state_t  : scheduler FSM states
//   DEF_WIDTH     : default number of bits per word
//   DEF_FLAG_LAT  : default detector latency (bit in -> flag out), in cycles
//   cnt_width()   : width of a counter that must hold values 0..n-1
// ---------------------------------------------------------------------------
package seq_detect_ctrl_pkg;

    // Scheduler phases, in the order a word passes through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    localparam int DEF_WIDTH    = 36;
    localparam int DEF_FLAG_LAT = 1;

    // A counter stepping through 0..n-1 needs clog2(n) bits, but never
    // fewer than one so that n == 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : seq_detect_ctrl_pkg

// File: rtl/seq_detect_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//
// Two-way round-robin arbiter with a one-bit "last served" memory.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (last served returns to 1)
//   en   : arbitration enable; grants and the memory update only when high
//   req  : request vector, bit i belongs to requester i
//   gnt  : one-hot grant, combinational from req while en is high
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_id_q;
    logic last_id_d;

    // Grant decision. A lone request always wins; on a tie the requester
    // that was not served last gets the slot. Because last_id resets to 1,
    // requester 0 takes the very first tie. The memory only moves when a
    // grant is actually issued.
    always_comb begin
        gnt       = 2'b00;
        last_id_d = last_id_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_id_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
            if (|req) begin
                last_id_d = gnt[1];
            end
        end
    end

    // Last-served register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_id_q <= 1'b1;
        end else begin
            last_id_q <= last_id_d;
        end
    end

endmodule : rr_arb2

// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl
//
// Scheduler that feeds words from two parallel requesters, one at a time,
// into an external serial sequence detector and counts its match flags.
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   req0/req1           : requests, held with stable data until granted
//   data0/data1         : WIDTH-bit words offered by the requesters
//   gnt0/gnt1           : one-cycle accept pulse; data captured on that edge
//   det_clr             : one-cycle clear pulse to the detector
//   det_din             : serial bit to the detector, MSB first
//   det_valid           : high while det_din carries a word bit
//   det_flag            : detector match output
//   busy                : high whenever the scheduler is not idle
//   done                : one-cycle completion pulse
//   done_id             : requester of the finished word (held)
//   hit_cnt             : flags counted for the finished word (held)
//
// Word timeline, cycle 0 being the idle cycle that grants:
//   1 clear, 2..WIDTH+1 shift, then FLAG_LAT drain cycles, then done;
//   the next grant can happen the cycle after done.
// ---------------------------------------------------------------------------
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int FLAG_LAT = DEF_FLAG_LAT,
    parameter int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             det_clr,
    output logic             det_din,
    output logic             det_valid,
    input  logic             det_flag,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CW-1:0]    hit_cnt
);

    localparam int DW = cnt_width(FLAG_LAT);

    ctrl_state_t         state_q,     state_d;
    logic [WIDTH-1:0]    shreg_q,     shreg_d;
    logic [CW-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [CW-1:0]       hit_acc_q,   hit_acc_d;
    logic [FLAG_LAT-1:0] vld_pipe_q,  vld_pipe_d;
    logic                cur_id_q,    cur_id_d;
    logic [CW-1:0]       hit_cnt_q,   hit_cnt_d;
    logic                done_id_q,   done_id_d;
    logic                done_q,      done_d;
    logic                det_clr_q,   det_clr_d;
    logic                det_din_q,   det_din_d;
    logic                det_valid_q, det_valid_d;
    logic                busy_q,      busy_d;

    logic [1:0]          arb_gnt;
    logic                arb_en;
    logic                flag_hit;
    logic [CW-1:0]       hit_acc_inc;

    // The arbiter only looks at requests while idle. Holding it off during
    // reset keeps a waiting request from being "accepted" on a reset edge,
    // which would lose the word without the requester noticing.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({req1, req0}),
        .gnt (arb_gnt)
    );

    // Flag qualification. det_valid is delayed by the detector latency so
    // that the tail of the delay line lines up with the flag produced by the
    // corresponding bit; a flag is only counted when that tail is high, which
    // masks anything the detector emits during idle, clear or drain.
    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        vld_pipe_d[0] = det_valid_q;
        for (int i = 1; i < FLAG_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
        flag_hit    = det_flag & vld_pipe_q[FLAG_LAT-1];
        hit_acc_inc = hit_acc_q + CW'(flag_hit);
    end

    // Next-state and next-output logic. Outputs are registered, so each
    // branch sets up what the outputs must show during the state being
    // entered: the clear pulse is prepared on the grant, the first serial
    // bit is prepared while leaving CLEAR, and so on. The shift register is
    // advanced every time a bit is handed to det_din_q so that its MSB is
    // always the next bit to send.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        drain_cnt_d = drain_cnt_q;
        hit_acc_d   = hit_acc_inc;
        cur_id_d    = cur_id_q;
        hit_cnt_d   = hit_cnt_q;
        done_id_d   = done_id_q;
        done_d      = 1'b0;
        det_clr_d   = 1'b0;
        det_din_d   = 1'b0;
        det_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    shreg_d   = arb_gnt[0] ? data0 : data1;
                    cur_id_d  = arb_gnt[1];
                    det_clr_d = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                bit_cnt_d   = '0;
                hit_acc_d   = '0;
                det_valid_d = 1'b1;
                det_din_d   = shreg_q[WIDTH-1];
                shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
                state_d     = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    drain_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end else begin
                    bit_cnt_d   = bit_cnt_q + CW'(1);
                    det_valid_d = 1'b1;
                    det_din_d   = shreg_q[WIDTH-1];
                    shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
                end
            end

            ST_DRAIN: begin
                if (drain_cnt_q == DW'(FLAG_LAT - 1)) begin
                    hit_cnt_d = hit_acc_inc;
                    done_id_d = cur_id_q;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // All scheduler state and registered outputs. Reset drops any word in
    // flight: the partial count is thrown away and no done is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            drain_cnt_q <= '0;
            hit_acc_q   <= '0;
            vld_pipe_q  <= '0;
            cur_id_q    <= 1'b0;
            hit_cnt_q   <= '0;
            done_id_q   <= 1'b0;
            done_q      <= 1'b0;
            det_clr_q   <= 1'b0;
            det_din_q   <= 1'b0;
            det_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            hit_acc_q   <= hit_acc_d;
            vld_pipe_q  <= vld_pipe_d;
            cur_id_q    <= cur_id_d;
            hit_cnt_q   <= hit_cnt_d;
            done_id_q   <= done_id_d;
            done_q      <= done_d;
            det_clr_q   <= det_clr_d;
            det_din_q   <= det_din_d;
            det_valid_q <= det_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt0      = arb_gnt[0];
    assign gnt1      = arb_gnt[1];
    assign det_clr   = det_clr_q;
    assign det_din   = det_din_q;
    assign det_valid = det_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign hit_cnt   = hit_cnt_q;

endmodule : seq_detect_ctrl
